// File: rtl/deal_sequencer_if.sv
// Handshake and status bundle between the deal sequencer and its environment.
interface deal_sequencer_if;
    logic       start;
    logic       hit;
    logic       stand;
    logic       card_req;
    logic       card_ready;
    logic [5:0] card_data;
    logic       hand_clr;
    logic       p_wen;
    logic       d_wen;
    logic [2:0] wraddr;
    logic [6:0] wdata;
    logic [2:0] p_count;
    logic [2:0] d_count;
    logic [5:0] p_total;
    logic [5:0] d_total;
    logic [1:0] result;
    logic       busy;
    logic       err;

    modport master (
        output start, hit, stand, card_ready, card_data,
        input  card_req, hand_clr, p_wen, d_wen, wraddr, wdata,
               p_count, d_count, p_total, d_total, result, busy, err
    );

    modport slave (
        input  start, hit, stand, card_ready, card_data,
        output card_req, hand_clr, p_wen, d_wen, wraddr, wdata,
               p_count, d_count, p_total, d_total, result, busy, err
    );
endinterface

// File: rtl/deal_sequencer.sv
// Blackjack round sequencer: deals, runs player/dealer turns, settles the round.
// All outputs are registered; a card accepted in cycle t is written in cycle t+1.
module deal_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    deal_sequencer_if.slave    bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,  S_CLR     = 4'd1,  S_DEAL_P0 = 4'd2,  S_DEAL_D0 = 4'd3,
        S_DEAL_P1 = 4'd4,  S_DEAL_D1 = 4'd5,  S_P_TURN  = 4'd6,  S_P_DRAW  = 4'd7,
        S_D_TURN  = 4'd8,  S_D_DRAW  = 4'd9,  S_SETTLE  = 4'd10, S_DONE    = 4'd11
    } state_t;

    // Hard value of a card: ace counts 1, pips rank+1, faces 10.
    function automatic logic [3:0] card_value(input logic [5:0] idx);
        logic [5:0] rank;
        rank = idx % 6'd13;
        if (rank == 6'd0)      card_value = 4'd1;
        else if (rank <= 6'd9) card_value = rank[3:0] + 4'd1;
        else                   card_value = 4'd10;
    endfunction

    // Best total: promote one ace to 11 when that cannot bust the hand.
    function automatic logic [5:0] best_total(input logic [5:0] hard, input logic ace);
        if (ace && (hard <= 6'd11)) best_total = hard + 6'd10;
        else                        best_total = hard;
    endfunction

    state_t     state_r, next_state_s;
    logic       card_req_r, hand_clr_r, p_wen_r, d_wen_r, busy_r, err_r;
    logic [2:0] wraddr_r, p_count_r, d_count_r;
    logic [6:0] wdata_r;
    logic [5:0] p_hard_r, d_hard_r, p_total_r, d_total_r;
    logic       p_ace_r, d_ace_r;
    logic [1:0] result_r;

    logic       card_state_s, to_player_s, accept_s, bad_card_s, start_ok_s;
    logic [3:0] card_val_s;
    logic [5:0] new_hard_s, new_total_s;
    logic       new_ace_s;
    logic [2:0] tgt_count_s;
    logic [1:0] settle_result_s;

    // Card handshake decode and running-total update for the hand being dealt to.
    always_comb begin
        card_state_s = 1'b0;
        to_player_s  = 1'b0;
        case (state_r)
            S_DEAL_P0, S_DEAL_P1, S_P_DRAW: begin card_state_s = 1'b1; to_player_s = 1'b1; end
            S_DEAL_D0, S_DEAL_D1, S_D_DRAW: begin card_state_s = 1'b1; to_player_s = 1'b0; end
            default:                        begin card_state_s = 1'b0; to_player_s = 1'b0; end
        endcase
        accept_s    = card_state_s && card_req_r && bus.card_ready && (bus.card_data <= 6'd51);
        bad_card_s  = card_state_s && card_req_r && bus.card_ready && (bus.card_data >  6'd51);
        start_ok_s  = bus.start && ((state_r == S_IDLE) || (state_r == S_DONE));
        card_val_s  = card_value(bus.card_data);
        tgt_count_s = to_player_s ? p_count_r : d_count_r;
        new_hard_s  = (to_player_s ? p_hard_r : d_hard_r) + {2'b00, card_val_s};
        new_ace_s   = (to_player_s ? p_ace_r : d_ace_r) | (card_val_s == 4'd1);
        new_total_s = best_total(new_hard_s, new_ace_s);
    end

    // Round outcome from the final totals; player bust takes priority.
    always_comb begin
        settle_result_s = 2'b00;
        if (p_total_r > 6'd21)           settle_result_s = 2'b10;
        else if (d_total_r > 6'd21)      settle_result_s = 2'b01;
        else if (p_total_r > d_total_r)  settle_result_s = 2'b01;
        else if (p_total_r < d_total_r)  settle_result_s = 2'b10;
        else                             settle_result_s = 2'b11;
    end

    // Next-state logic of the round FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: next_state_s = start_ok_s ? S_CLR : state_r;
            S_CLR:          next_state_s = S_DEAL_P0;
            S_DEAL_P0:      next_state_s = accept_s ? S_DEAL_D0 : state_r;
            S_DEAL_D0:      next_state_s = accept_s ? S_DEAL_P1 : state_r;
            S_DEAL_P1:      next_state_s = accept_s ? S_DEAL_D1 : state_r;
            S_DEAL_D1:      next_state_s = accept_s ? S_P_TURN  : state_r;
            S_P_TURN: begin
                if (p_total_r > 6'd21)                              next_state_s = S_SETTLE;
                else if ((p_total_r == 6'd21) || (p_count_r == 3'd5)) next_state_s = S_D_TURN;
                else if (bus.stand)                                 next_state_s = S_D_TURN;
                else if (bus.hit)                                   next_state_s = S_P_DRAW;
                else                                                next_state_s = state_r;
            end
            S_P_DRAW:       next_state_s = accept_s ? S_P_TURN : state_r;
            S_D_TURN: begin
                if ((d_total_r < 6'd17) && (d_count_r < 3'd5)) next_state_s = S_D_DRAW;
                else                                           next_state_s = S_SETTLE;
            end
            S_D_DRAW:       next_state_s = accept_s ? S_D_TURN : state_r;
            S_SETTLE:       next_state_s = S_DONE;
            default:        next_state_s = S_IDLE;
        endcase
    end

    // State register and all registered outputs, hand bookkeeping included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            card_req_r <= 1'b0;  hand_clr_r <= 1'b0;  p_wen_r <= 1'b0;  d_wen_r <= 1'b0;
            busy_r     <= 1'b0;  err_r      <= 1'b0;
            wraddr_r   <= 3'd0;  wdata_r    <= 7'd0;
            p_count_r  <= 3'd0;  d_count_r  <= 3'd0;
            p_hard_r   <= 6'd0;  d_hard_r   <= 6'd0;  p_ace_r <= 1'b0;  d_ace_r <= 1'b0;
            p_total_r  <= 6'd0;  d_total_r  <= 6'd0;
            result_r   <= 2'b00;
        end else begin
            state_r    <= next_state_s;
            hand_clr_r <= start_ok_s;
            busy_r     <= (next_state_s != S_IDLE) && (next_state_s != S_DONE);
            card_req_r <= !accept_s && ((next_state_s == S_DEAL_P0) || (next_state_s == S_DEAL_D0) ||
                                        (next_state_s == S_DEAL_P1) || (next_state_s == S_DEAL_D1) ||
                                        (next_state_s == S_P_DRAW)  || (next_state_s == S_D_DRAW));
            p_wen_r    <= accept_s && to_player_s;
            d_wen_r    <= accept_s && !to_player_s;
            if (start_ok_s) begin
                p_count_r <= 3'd0;  d_count_r <= 3'd0;
                p_hard_r  <= 6'd0;  d_hard_r  <= 6'd0;  p_ace_r <= 1'b0;  d_ace_r <= 1'b0;
                p_total_r <= 6'd0;  d_total_r <= 6'd0;
                result_r  <= 2'b00;
                err_r     <= 1'b0;
            end else begin
                if (bad_card_s) err_r <= 1'b1;
                if (state_r == S_SETTLE) result_r <= settle_result_s;
                if (accept_s) begin
                    wraddr_r <= tgt_count_s;
                    wdata_r  <= {1'b0, bus.card_data};
                    if (to_player_s) begin
                        p_count_r <= p_count_r + 3'd1;
                        p_hard_r  <= new_hard_s;
                        p_ace_r   <= new_ace_s;
                        p_total_r <= new_total_s;
                    end else begin
                        d_count_r <= d_count_r + 3'd1;
                        d_hard_r  <= new_hard_s;
                        d_ace_r   <= new_ace_s;
                        d_total_r <= new_total_s;
                    end
                end
            end
        end
    end

    assign bus.card_req = card_req_r;
    assign bus.hand_clr = hand_clr_r;
    assign bus.p_wen    = p_wen_r;
    assign bus.d_wen    = d_wen_r;
    assign bus.wraddr   = wraddr_r;
    assign bus.wdata    = wdata_r;
    assign bus.p_count  = p_count_r;
    assign bus.d_count  = d_count_r;
    assign bus.p_total  = p_total_r;
    assign bus.d_total  = d_total_r;
    assign bus.result   = result_r;
    assign bus.busy     = busy_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: hand writes are scoreboarded against a
// small blackjack model; round outcomes are checked against hand-derived values.
module tb_deal_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total_n = 0;
    int   bad_n = 0;

    deal_sequencer_if bus();

    deal_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       pl;
        logic [2:0] addr;
        logic [6:0] data;
        logic [5:0] tot;
    } wr_t;

    wr_t sb[$];
    int  m_hard[2];
    int  m_ace[2];
    int  m_cnt[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int val(input int c);
        int r;
        r = c % 13;
        if (r == 0)      return 1;
        else if (r <= 9) return r + 1;
        else             return 10;
    endfunction

    function automatic int best(input int h, input int a);
        return ((a != 0) && (h <= 11)) ? h + 10 : h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_hard[i] = 0; m_ace[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.p_wen || bus.d_wen) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_wen", 32'(bus.p_wen | bus.d_wen), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wen_p", 32'(bus.p_wen), 32'(e.pl));
                check("wen_d", 32'(bus.d_wen), 32'(!e.pl));
                check("wraddr", 32'(bus.wraddr), 32'(e.addr));
                check("wdata", 32'(bus.wdata), 32'(e.data));
                check("total_upd", 32'(e.pl ? bus.p_total : bus.d_total), 32'(e.tot));
                check("count_upd", 32'(e.pl ? bus.p_count : bus.d_count), 32'(e.addr) + 32'd1);
            end
        end
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.card_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("card_req_wait", 32'(bus.card_req), 32'd1);
    endtask

    task automatic give(input int card, input bit pl);
        wr_t e;
        int  idx;
        wait_req();
        bus.card_ready = 1'b1;
        bus.card_data  = 6'(card);
        if (card <= 51) begin
            idx = pl ? 1 : 0;
            e.pl   = pl;
            e.addr = 3'(m_cnt[idx]);
            e.data = 7'(card);
            m_cnt[idx]++;
            m_hard[idx] += val(card);
            if (val(card) == 1) m_ace[idx] = 1;
            e.tot = 6'(best(m_hard[idx], m_ace[idx]));
            sb.push_back(e);
        end
        @(negedge clk);
        bus.card_ready = 1'b0;
        if (card <= 51) begin
            check("card_req_drop", 32'(bus.card_req), 32'd0);
        end else begin
            check("card_req_hold", 32'(bus.card_req), 32'd1);
            check("err_set", 32'(bus.err), 32'd1);
            check("bad_no_wen", 32'(bus.p_wen | bus.d_wen), 32'd0);
        end
    endtask

    task automatic do_start();
        model_clear();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("clr_pulse", 32'(bus.hand_clr), 32'd1);
        check("clr_busy", 32'(bus.busy), 32'd1);
        check("clr_pcount", 32'(bus.p_count), 32'd0);
        check("clr_dcount", 32'(bus.d_count), 32'd0);
        check("clr_err", 32'(bus.err), 32'd0);
        check("clr_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        check("clr_one_cycle", 32'(bus.hand_clr), 32'd0);
    endtask

    task automatic pulse(input bit h, input bit s);
        bus.hit = h;
        bus.stand = s;
        @(negedge clk);
        bus.hit = 1'b0;
        bus.stand = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.hit = 1'b0; bus.stand = 1'b0;
        bus.card_ready = 1'b0; bus.card_data = 6'd0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_card_req", 32'(bus.card_req), 32'd0);
        check("rst_hand_clr", 32'(bus.hand_clr), 32'd0);
        check("rst_wen", 32'({bus.p_wen, bus.d_wen}), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_wraddr", 32'(bus.wraddr), 32'd0);
        check("rst_wdata", 32'(bus.wdata), 32'd0);
        check("rst_counts", 32'({bus.p_count, bus.d_count}), 32'd0);
        check("rst_totals", 32'({bus.p_total, bus.d_total}), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // hit/stand in IDLE are ignored
        pulse(1'b1, 1'b1);
        check("idle_ignore_busy", 32'(bus.busy), 32'd0);
        check("idle_ignore_req", 32'(bus.card_req), 32'd0);

        // Player blackjack auto-stands, dealer 16 draws to 21: push
        do_start();
        give(0, 1'b1);
        give(12, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("start_ignored_clr", 32'(bus.hand_clr), 32'd0);
        check("start_ignored_cnt", 32'(bus.d_count), 32'd1);
        give(9, 1'b1);
        check("bj_p_total", 32'(bus.p_total), 32'd21);
        give(5, 1'b0);
        give(4, 1'b0);
        wait_done();
        check("bj_result", 32'(bus.result), 32'd3);
        check("bj_d_count", 32'(bus.d_count), 32'd3);
        check("bj_d_total", 32'(bus.d_total), 32'd21);

        // Player hits and busts: dealer wins, no further cards
        do_start();
        give(8, 1'b1);
        give(1, 1'b0);
        give(7, 1'b1);
        give(2, 1'b0);
        pulse(1'b1, 1'b0);
        give(11, 1'b1);
        wait_done();
        check("bust_p_total", 32'(bus.p_total), 32'd27);
        check("bust_result", 32'(bus.result), 32'd2);
        check("bust_d_count", 32'(bus.d_count), 32'd2);
        repeat (4) @(negedge clk);
        check("bust_no_req", 32'(bus.card_req), 32'd0);
        check("bust_result_held", 32'(bus.result), 32'd2);

        // hit and stand together: stand wins, dealer draws to 21
        do_start();
        give(8, 1'b1);
        give(1, 1'b0);
        give(7, 1'b1);
        give(2, 1'b0);
        pulse(1'b1, 1'b1);
        give(9, 1'b0);
        give(5, 1'b0);
        wait_done();
        check("hs_p_count", 32'(bus.p_count), 32'd2);
        check("hs_d_count", 32'(bus.d_count), 32'd4);
        check("hs_result", 32'(bus.result), 32'd2);

        // Out-of-range card sets sticky err and is not written
        do_start();
        give(60, 1'b1);
        give(3, 1'b1);
        give(10, 1'b0);
        give(9, 1'b1);
        give(11, 1'b0);
        pulse(1'b0, 1'b1);
        wait_done();
        check("err_sticky", 32'(bus.err), 32'd1);
        check("err_round_result", 32'(bus.result), 32'd2);

        // Reset during DEAL_D0 abandons the round
        do_start();
        give(5, 1'b1);
        @(negedge clk);
        check("pre_rst_req", 32'(bus.card_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req", 32'(bus.card_req), 32'd0);
        check("midrst_p_count", 32'(bus.p_count), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_p_total", 32'(bus.p_total), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        give(0, 1'b1);
        give(12, 1'b0);
        give(9, 1'b1);
        give(5, 1'b0);
        give(4, 1'b0);
        wait_done();
        check("postrst_result", 32'(bus.result), 32'd3);

        // Five-card hand auto-stands at 12; dealer 20 wins
        do_start();
        give(1, 1'b1);
        give(10, 1'b0);
        give(2, 1'b1);
        give(11, 1'b0);
        pulse(1'b1, 1'b0);
        give(14, 1'b1);
        pulse(1'b1, 1'b0);
        give(15, 1'b1);
        pulse(1'b1, 1'b0);
        give(27, 1'b1);
        wait_done();
        check("five_p_count", 32'(bus.p_count), 32'd5);
        check("five_p_total", 32'(bus.p_total), 32'd12);
        check("five_d_count", 32'(bus.d_count), 32'd2);
        check("five_result", 32'(bus.result), 32'd2);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
